// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 pipeline: access-size encodings, MEM-stage
// FSM states and WB control-field layout.
package mips_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    localparam int          WB_W         = 3;
    localparam int          WB_REG_WRITE = 0;
    localparam int          WB_MEM_TO_REG = 1;
    localparam logic [2:0]  WB_NONE      = 3'b000;

    // Reserved size behaves as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational store lane replication / byte enables and load
// lane extraction with sign or zero extension.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
        lane_byte = load_word[7:0];
        lane_half = load_word[15:0];
        case (addr_lo)
            2'b00:   lane_byte = load_word[7:0];
            2'b01:   lane_byte = load_word[15:8];
            2'b10:   lane_byte = load_word[23:16];
            default: lane_byte = load_word[31:24];
        endcase
        lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = load_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            end
            SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = load_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = load_word;
            end
        endcase
    end

    assign misaligned = is_misaligned(size, addr_lo);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data bus with a req/ack handshake, times out stuck
// requests, stalls upstream while busy. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [2:0]  wb_in,
    input  logic [4:0]  direccion_in,
    input  logic [31:0] jump_address_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] Read_data,
    output logic [31:0] Alu_result,
    output logic [2:0]  WB,
    output logic [4:0]  direccion,
    output logic [31:0] jump_address,
    output logic        bus_error
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rd_q;
    logic             err_q;
    logic [1:0]       size_q;
    logic [1:0]       lo_q;
    logic             uns_q;
    logic             load_q;

    logic        access;
    logic [1:0]  sel_size;
    logic [1:0]  sel_lo;
    logic        sel_uns;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
    logic        misaligned;

    assign access = in_valid & (mem_read | mem_write);

    // Issue uses the live EX/MEM fields; formatting at ack uses the captured ones.
    assign sel_size = (state == ST_IDLE) ? mem_size : size_q;
    assign sel_lo   = (state == ST_IDLE) ? alu_result[1:0] : lo_q;
    assign sel_uns  = (state == ST_IDLE) ? load_unsigned : uns_q;

    mem_lane_align u_lane (
        .size          (sel_size),
        .addr_lo       (sel_lo),
        .load_unsigned (sel_uns),
        .store_data    (write_data),
        .load_word     (mem_rdata),
        .be            (lane_be),
        .wdata         (lane_wdata),
        .load_data     (lane_load),
        .misaligned    (misaligned)
    );

    always_comb begin
        stall = 1'b0;
        case (state)
            ST_IDLE: stall = access;
            ST_REQ:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
        stall = stall & rst_n;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            size_q    <= SIZE_WORD;
            lo_q      <= 2'b00;
            uns_q     <= 1'b0;
            load_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (access) begin
                        if (TRAP_EN && misaligned) begin
                            rd_q  <= '0;
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write;
                            mem_addr  <= {alu_result[31:2], 2'b00};
                            mem_be    <= lane_be;
                            mem_wdata <= lane_wdata;
                            size_q    <= mem_size;
                            lo_q      <= alu_result[1:0];
                            uns_q     <= load_unsigned;
                            load_q    <= ~mem_write;
                            cnt       <= '0;
                            rd_q      <= '0;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        rd_q    <= load_q ? lane_load : 32'h0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rd_q    <= '0;
                        err_q   <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Read_data    = (state == ST_DONE) ? rd_q : 32'h0;
    assign bus_error    = (state == ST_DONE) && err_q;
    assign WB           = bus_error ? WB_NONE : wb_in;
    assign Alu_result   = alu_result;
    assign direccion    = direccion_in;
    assign jump_address = jump_address_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: retire and bus expectations are queued
// by the stimulus and checked by independent monitors.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [2:0]  wb_in;
    logic [4:0]  direccion_in;
    logic [31:0] jump_address_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] Read_data;
    logic [31:0] Alu_result;
    logic [2:0]  WB;
    logic [4:0]  direccion;
    logic [31:0] jump_address;
    logic        bus_error;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .alu_result      (alu_result),
        .write_data      (write_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_size        (mem_size),
        .load_unsigned   (load_unsigned),
        .wb_in           (wb_in),
        .direccion_in    (direccion_in),
        .jump_address_in (jump_address_in),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .stall           (stall),
        .Read_data       (Read_data),
        .Alu_result      (Alu_result),
        .WB              (WB),
        .direccion       (direccion),
        .jump_address    (jump_address),
        .bus_error       (bus_error)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [2:0]  wb;
        logic [4:0]  dir;
        logic [31:0] jmp;
        logic        berr;
        int          stalls;
    } ret_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    ret_t ret_q[$];
    bus_t bus_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Retire monitor: an instruction leaves MEM whenever it is valid and not stalled.
    int stall_run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_run = 0;
        end else if (in_valid && !stall) begin
            if (ret_q.size() == 0) begin
                check("unexpected_retire", 32'd1, 32'd0);
            end else begin
                ret_t e;
                e = ret_q.pop_front();
                check("Read_data",    Read_data,          e.rd);
                check("Alu_result",   Alu_result,         e.alu);
                check("WB",           {29'h0, WB},        {29'h0, e.wb});
                check("direccion",    {27'h0, direccion}, {27'h0, e.dir});
                check("jump_address", jump_address,       e.jmp);
                check("bus_error",    {31'h0, bus_error}, {31'h0, e.berr});
                check("stall_cycles", stall_run,          e.stalls);
            end
            stall_run = 0;
        end else if (stall) begin
            stall_run++;
        end
    end

    // Bus monitor: checks fields on each new request and its length when it drops.
    logic req_prev = 1'b0;
    int   req_len  = 0;
    int   cur_len  = -1;
    always @(negedge clk) begin
        if (!rst_n) begin
            req_prev = 1'b0;
            req_len  = 0;
        end else begin
            if (mem_req && !req_prev) begin
                req_len = 1;
                if (bus_q.size() == 0) begin
                    check("unexpected_mem_req", 32'd1, 32'd0);
                    cur_len = -1;
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    check("mem_we",    {31'h0, mem_we},  {31'h0, b.we});
                    check("mem_addr",  mem_addr,         b.addr);
                    check("mem_be",    {28'h0, mem_be},  {28'h0, b.be});
                    check("mem_wdata", mem_wdata,        b.wdata);
                    cur_len = b.len;
                end
            end else if (mem_req) begin
                req_len++;
            end else if (req_prev && cur_len >= 0) begin
                check("mem_req_cycles", req_len, cur_len);
            end
            req_prev = mem_req;
        end
    end

    task automatic exp_ret(input logic [31:0] rd, input logic [31:0] alu, input logic [2:0] wb,
                           input logic [4:0] dir, input logic [31:0] jmp, input logic berr,
                           input int stalls);
        ret_t e;
        e.rd = rd; e.alu = alu; e.wb = wb; e.dir = dir; e.jmp = jmp; e.berr = berr; e.stalls = stalls;
        ret_q.push_back(e);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int len);
        bus_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.len = len;
        bus_q.push_back(b);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] wb,
                         input logic [4:0] dir, input logic [31:0] jmp);
        in_valid        = 1'b1;
        mem_read        = rd;
        mem_write       = wr;
        mem_size        = sz;
        load_unsigned   = uns;
        alu_result      = alu;
        write_data      = wd;
        wb_in           = wb;
        direccion_in    = dir;
        jump_address_in = jmp;
    endtask

    // Holds one instruction until it retires; acks on the ack_after-th REQ cycle (0 = never).
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] wb,
                          input logic [4:0] dir, input logic [31:0] jmp,
                          input int ack_after, input logic [31:0] rdata);
        int  req_cnt;
        bit  done;
        req_cnt = 0;
        done    = 1'b0;
        drive(rd, wr, sz, uns, alu, wd, wb, dir, jmp);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cnt++;
                if (req_cnt == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (!stall) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_retire_timeout: instruction at 0x%08h did not retire within 100 cycles", alu);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        alu_result      = '0;
        write_data      = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_size        = 2'b10;
        load_unsigned   = 1'b0;
        wb_in           = '0;
        direccion_in    = '0;
        jump_address_in = '0;
        mem_ack         = 1'b0;
        mem_rdata       = '0;

        #1;
        check("rst_mem_req",   {31'h0, mem_req},   32'h0);
        check("rst_mem_we",    {31'h0, mem_we},    32'h0);
        check("rst_mem_be",    {28'h0, mem_be},    32'h0);
        check("rst_stall",     {31'h0, stall},     32'h0);
        check("rst_bus_error", {31'h0, bus_error}, 32'h0);
        check("rst_Read_data", Read_data,          32'h0);

        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Non-memory op passes straight through.
        exp_ret(32'h0, 32'h0000_1234, 3'b101, 5'd5, 32'h0000_0400, 1'b0, 0);
        run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 3'b101, 5'd5, 32'h0000_0400, 0, 32'h0);

        // lw 0x100, ack on second REQ cycle.
        exp_bus(1'b0, 32'h0000_0100, 4'b1111, 32'h1111_1111, 2);
        exp_ret(32'hDEAD_BEEF, 32'h0000_0100, 3'b011, 5'd8, 32'h0000_0404, 1'b0, 3);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h1111_1111, 3'b011, 5'd8, 32'h0000_0404, 2, 32'hDEAD_BEEF);

        // lb / lbu 0x103, top byte 0x80.
        exp_bus(1'b0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 1);
        exp_ret(32'hFFFF_FF80, 32'h0000_0103, 3'b011, 5'd9, 32'h0000_0408, 1'b0, 2);
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 3'b011, 5'd9, 32'h0000_0408, 1, 32'h8012_3456);
        exp_bus(1'b0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 1);
        exp_ret(32'h0000_0080, 32'h0000_0103, 3'b011, 5'd10, 32'h0000_040C, 1'b0, 2);
        run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 3'b011, 5'd10, 32'h0000_040C, 1, 32'h8012_3456);

        // sh 0x202 and sb 0x201.
        exp_bus(1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1);
        exp_ret(32'h0, 32'h0000_0202, 3'b000, 5'd0, 32'h0000_0410, 1'b0, 2);
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 3'b000, 5'd0, 32'h0000_0410, 1, 32'h0);
        exp_bus(1'b1, 32'h0000_0200, 4'b0010, 32'hEEEE_EEEE, 1);
        exp_ret(32'h0, 32'h0000_0201, 3'b000, 5'd0, 32'h0000_0414, 1'b0, 2);
        run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_56EE, 3'b000, 5'd0, 32'h0000_0414, 1, 32'h0);

        // lh signed upper half, lhu lower half.
        exp_bus(1'b0, 32'h0000_0100, 4'b1100, 32'h0000_0000, 1);
        exp_ret(32'hFFFF_8001, 32'h0000_0102, 3'b011, 5'd11, 32'h0000_0418, 1'b0, 2);
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 3'b011, 5'd11, 32'h0000_0418, 1, 32'h8001_7FFF);
        exp_bus(1'b0, 32'h0000_0100, 4'b0011, 32'h0000_0000, 1);
        exp_ret(32'h0000_ABCD, 32'h0000_0100, 3'b011, 5'd12, 32'h0000_041C, 1'b0, 2);
        run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 3'b011, 5'd12, 32'h0000_041C, 1, 32'h1234_ABCD);

        // sw with ack on third REQ cycle; read+write together acts as a store.
        exp_bus(1'b1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 3);
        exp_ret(32'h0, 32'h0000_0300, 3'b000, 5'd0, 32'h0000_0420, 1'b0, 4);
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 3'b000, 5'd0, 32'h0000_0420, 3, 32'h0);
        exp_bus(1'b1, 32'h0000_0304, 4'b1111, 32'h5555_AAAA, 1);
        exp_ret(32'h0, 32'h0000_0304, 3'b010, 5'd13, 32'h0000_0424, 1'b0, 2);
        run_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'h5555_AAAA, 3'b010, 5'd13, 32'h0000_0424, 1, 32'h7777_7777);

        // Reserved size behaves as a word.
        exp_bus(1'b0, 32'h0000_0308, 4'b1111, 32'h0000_0000, 1);
        exp_ret(32'h8765_4321, 32'h0000_0308, 3'b011, 5'd14, 32'h0000_0428, 1'b0, 2);
        run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0308, 32'h0, 3'b011, 5'd14, 32'h0000_0428, 1, 32'h8765_4321);

        // Misaligned accesses.
`ifdef MEM_MISALIGN_TRAP_EN
        exp_ret(32'h0, 32'h0000_0101, 3'b000, 5'd15, 32'h0000_042C, 1'b1, 1);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 3'b011, 5'd15, 32'h0000_042C, 1, 32'h0102_0304);
        exp_ret(32'h0, 32'h0000_0203, 3'b000, 5'd16, 32'h0000_0430, 1'b1, 1);
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0, 3'b011, 5'd16, 32'h0000_0430, 1, 32'hBEEF_0000);
`else
        exp_bus(1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 1);
        exp_ret(32'h0102_0304, 32'h0000_0101, 3'b011, 5'd15, 32'h0000_042C, 1'b0, 2);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 3'b011, 5'd15, 32'h0000_042C, 1, 32'h0102_0304);
        exp_bus(1'b0, 32'h0000_0200, 4'b1100, 32'h0000_0000, 1);
        exp_ret(32'hFFFF_BEEF, 32'h0000_0203, 3'b011, 5'd16, 32'h0000_0430, 1'b0, 2);
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0, 3'b011, 5'd16, 32'h0000_0430, 1, 32'hBEEF_0000);
`endif

        // No ack: request lasts 16 cycles, then error with WB squashed.
        exp_bus(1'b0, 32'h0000_0500, 4'b1111, 32'h0000_0000, 16);
        exp_ret(32'h0, 32'h0000_0500, 3'b000, 5'd17, 32'h0000_0434, 1'b1, 17);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 3'b111, 5'd17, 32'h0000_0434, 0, 32'h0);

        // Load with in_valid low is not an access.
        in_valid  = 1'b0;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        check("invalid_no_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        check("invalid_no_req", {31'h0, mem_req}, 32'h0);

        // Reset in the middle of REQ.
        exp_bus(1'b0, 32'h0000_0600, 4'b1111, 32'h0000_0000, -1);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 3'b011, 5'd18, 32'h0000_0438);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20 && seen < 3; i++) begin
                @(negedge clk);
                if (mem_req) seen++;
            end
            check("pre_rst_req_cycles", seen, 3);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_req",   {31'h0, mem_req},   32'h0);
        check("midrst_stall",     {31'h0, stall},     32'h0);
        check("midrst_bus_error", {31'h0, bus_error}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("late_ack_no_req",   {31'h0, mem_req},   32'h0);
        check("late_ack_no_error", {31'h0, bus_error}, 32'h0);
        check("late_ack_Read_data", Read_data,         32'h0);

        exp_ret(32'h0, 32'h0000_4321, 3'b001, 5'd19, 32'h0000_043C, 1'b0, 0);
        run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_4321, 32'h0, 3'b001, 5'd19, 32'h0000_043C, 0, 32'h0);

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ret_queue_drained", ret_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
